// File: rtl/block_gpio_input_pkg.sv
// -----------------------------------------------------------------------------
// block_gpio_input_pkg
// Shared definitions for the IO-extender digital input stage: SPI register
// map addresses for the input block, default channel/timing constants and the
// debounce counter width helper.
// -----------------------------------------------------------------------------
package block_gpio_input_pkg;

    // SPI register addresses owned by the input block
    typedef enum logic [7:0] {
        REG_IN_CTRL   = 8'h20,
        REG_IN_DATA   = 8'h21,
        REG_IN_STATUS = 8'h22,
        REG_IN_RISE   = 8'h23,
        REG_IN_FALL   = 8'h24
    } gpio_in_reg_e;

    localparam int GPIO_IN_WIDTH    = 7;
    localparam int SYNC_DEFAULT     = 2;
    localparam int DEBOUNCE_DEFAULT = 16;

    // Counter must be able to hold values 0..cycles
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/block_gpio_input_if.sv
// -----------------------------------------------------------------------------
// block_gpio_input_if
// Bundles the pad/control/status signals of the digital input stage.
//   master : drives pin_in, en, rise_mask, fall_mask, clr, clr_mask;
//            receives level, edge_status, irq
//   slave  : the input stage itself (mirror of master)
// -----------------------------------------------------------------------------
interface block_gpio_input_if
    import block_gpio_input_pkg::*;
#(
    parameter int WIDTH = GPIO_IN_WIDTH
);
    logic [WIDTH-1:0] pin_in;
    logic [WIDTH-1:0] en;
    logic [WIDTH-1:0] rise_mask;
    logic [WIDTH-1:0] fall_mask;
    logic             clr;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] edge_status;
    logic             irq;

    modport master (
        output pin_in, en, rise_mask, fall_mask, clr, clr_mask,
        input  level, edge_status, irq
    );

    modport slave (
        input  pin_in, en, rise_mask, fall_mask, clr, clr_mask,
        output level, edge_status, irq
    );
endinterface

// File: rtl/block_gpio_input_debounce.sv
// -----------------------------------------------------------------------------
// block_gpio_input_debounce
// One input channel: synchroniser chain, debounce counter, accepted level and
// single-cycle rise/fall indications that coincide with the clock edge on
// which the level register changes.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   pin         raw pad level (asynchronous to clk)
//   en          channel enable; when low, level and counter held at 0
//   level       debounced level (registered)
//   rise, fall  high during the cycle whose closing edge flips level
// -----------------------------------------------------------------------------
module block_gpio_input_debounce
    import block_gpio_input_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    input  logic en,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   s;
    logic                   accept;

    assign s      = sync_q[SYNC_STAGES-1];
    // The new level has persisted long enough: it is taken on this edge
    assign accept = en && (s != level_q) && (cnt_q == CNT_LAST);
    assign rise   = accept &  s;
    assign fall   = accept & ~s;
    assign level  = level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            // synchroniser stage boundary
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            // debounce stage boundary
            if (!en) begin
                // Dropping level here is not an edge; rise/fall stay low
                level_q <= 1'b0;
                cnt_q   <= '0;
            end else if (s == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= s;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/block_gpio_input.sv
// -----------------------------------------------------------------------------
// block_gpio_input
// Input-side stage of the IO extender. Each of WIDTH pad inputs is
// synchronised and debounced into the level byte (IN_DATA readback). With
// GPIO_IN_EDGE_IRQ_EN defined, accepted level changes selected by rise_mask /
// fall_mask set sticky edge_status bits (write-1-to-clear through clr /
// clr_mask, set has priority) and irq is the registered OR of the status.
// Without GPIO_IN_EDGE_IRQ_EN, edge_status and irq are tied low.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    block_gpio_input_if.slave: pin_in, en, rise_mask, fall_mask, clr,
//          clr_mask in; level, edge_status, irq out
// -----------------------------------------------------------------------------
module block_gpio_input
    import block_gpio_input_pkg::*;
#(
    parameter int WIDTH           = GPIO_IN_WIDTH,
    parameter int SYNC_STAGES     = SYNC_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    block_gpio_input_if.slave   bus
);
    logic [WIDTH-1:0] level_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        block_gpio_input_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .pin   (bus.pin_in[i]),
            .en    (bus.en[i]),
            .level (level_w[i]),
            .rise  (rise_w[i]),
            .fall  (fall_w[i])
        );
    end

    assign bus.level = level_w;

`ifdef GPIO_IN_EDGE_IRQ_EN
    // Clear first, then OR in new sets, so a coincident set survives
    function automatic logic [WIDTH-1:0] status_next(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] set,
        input logic             clr,
        input logic [WIDTH-1:0] mask
    );
        return (cur & ~(clr ? mask : '0)) | set;
    endfunction

    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] status_nxt;
    logic             irq_q;

    always_comb begin
        status_nxt = status_next(status_q,
                                 (rise_w & bus.rise_mask) | (fall_w & bus.fall_mask),
                                 bus.clr, bus.clr_mask);
    end

    // status stage boundary: irq is registered from the next status so it
    // rises together with edge_status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= status_nxt;
            irq_q    <= |status_nxt;
        end
    end

    assign bus.edge_status = status_q;
    assign bus.irq         = irq_q;
`else
    logic unused_edge;
    assign unused_edge     = ^{rise_w, fall_w, bus.rise_mask, bus.fall_mask,
                               bus.clr, bus.clr_mask};
    assign bus.edge_status = '0;
    assign bus.irq         = 1'b0;
`endif
endmodule

// File: tb/tb_block_gpio_input.sv
module tb_block_gpio_input;
    import block_gpio_input_pkg::*;

    localparam int W    = 7;
    localparam int SYNC = 2;
    localparam int DEB  = 16;
`ifdef GPIO_IN_EDGE_IRQ_EN
    localparam bit EDGE_ON = 1'b1;
`else
    localparam bit EDGE_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    block_gpio_input_if #(.WIDTH(W)) bus ();

    block_gpio_input #(
        .WIDTH           (W),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: a channel's level flips once the synchronised pin has
    // disagreed with it, channel enabled, for the last DEB consecutive edges.
    logic [W-1:0] pin_q[$];
    logic [W-1:0] s_q[$];
    logic [W-1:0] en_q[$];
    logic [W-1:0] m_level;
    logic [W-1:0] m_status;

    task automatic model_reset();
        pin_q.delete();
        s_q.delete();
        en_q.delete();
        for (int k = 0; k < SYNC; k++) pin_q.push_back('0);
        m_level  = '0;
        m_status = '0;
    endtask

    task automatic model_step();
        logic [W-1:0] s, nl, rise, fall;
        bit           stable;
        pin_q.push_back(bus.pin_in);
        s = pin_q[pin_q.size() - 1 - SYNC];
        s_q.push_back(s);
        en_q.push_back(bus.en);
        nl   = m_level;
        rise = '0;
        fall = '0;
        for (int i = 0; i < W; i++) begin
            if (!bus.en[i]) begin
                nl[i] = 1'b0;
            end else if (s_q.size() >= DEB) begin
                stable = 1'b1;
                for (int j = 0; j < DEB; j++) begin
                    if (s_q[s_q.size() - 1 - j][i] == m_level[i] ||
                        !en_q[en_q.size() - 1 - j][i]) stable = 1'b0;
                end
                if (stable) begin
                    nl[i]   = s[i];
                    rise[i] = s[i];
                    fall[i] = ~s[i];
                end
            end
        end
        if (EDGE_ON)
            m_status = (m_status & ~(bus.clr ? bus.clr_mask : '0)) |
                       (rise & bus.rise_mask) | (fall & bus.fall_mask);
        else
            m_status = '0;
        m_level = nl;
        while (pin_q.size() > SYNC + 4) void'(pin_q.pop_front());
        while (s_q.size() > DEB + 4)    void'(s_q.pop_front());
        while (en_q.size() > DEB + 4)   void'(en_q.pop_front());
    endtask

    // One clock: model follows the active edge, DUT compared on the falling edge
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        chk("level",  32'(bus.level),       32'(m_level));
        chk("status", 32'(bus.edge_status), 32'(m_status));
        chk("irq",    32'(bus.irq),         32'(|m_status));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Ticks until level[ch] equals val; returns cycles taken, 0 if bound expired
    task automatic wait_level(input int ch, input logic val, input int bound, output int cyc);
        cyc = 0;
        for (int k = 1; k <= bound; k++) begin
            tick();
            if (bus.level[ch] === val) begin
                cyc = k;
                break;
            end
        end
    endtask

    int lat;

    initial begin
        bus.pin_in    = '0;
        bus.en        = 7'h7F;
        bus.rise_mask = '0;
        bus.fall_mask = '0;
        bus.clr       = 1'b0;
        bus.clr_mask  = '0;
        model_reset();
        ticks(3);
        chk("rst_level",  32'(bus.level),       0);
        chk("rst_status", 32'(bus.edge_status), 0);
        chk("rst_irq",    32'(bus.irq),         0);
        rst_n = 1'b1;

        // 1: clean step latency SYNC+DEB
        bus.pin_in[0] = 1'b1;
        wait_level(0, 1'b1, 40, lat);
        chk("t1_latency", lat, SYNC + DEB);
        chk("t1_others", 32'(bus.level[6:1]), 0);

        // 2: 10-cycle pulse is rejected
        bus.pin_in[2] = 1'b1;
        ticks(10);
        bus.pin_in[2] = 1'b0;
        ticks(30);
        chk("t2_level2", 32'(bus.level[2]), 0);
        chk("t2_status", 32'(bus.edge_status), 0);

        // 3: rise/fall flags and clear
        bus.pin_in[0] = 1'b0;
        ticks(25);
        bus.rise_mask = 7'h01;
        bus.fall_mask = 7'h01;
        bus.pin_in[0] = 1'b1;
        ticks(20);
        chk("t3_status_rise", 32'(bus.edge_status), EDGE_ON ? 32'h01 : 32'h0);
        chk("t3_irq_rise",    32'(bus.irq),         EDGE_ON ? 32'h1  : 32'h0);
        bus.pin_in[0] = 1'b0;
        ticks(20);
        bus.clr      = 1'b1;
        bus.clr_mask = 7'h01;
        tick();
        bus.clr = 1'b0;
        chk("t3_status_clr", 32'(bus.edge_status), 0);
        chk("t3_irq_clr",    32'(bus.irq),         0);

        // 4: clear on the accepting edge loses to the set
        bus.pin_in[0] = 1'b1;
        ticks(SYNC + DEB - 1);
        bus.clr      = 1'b1;
        bus.clr_mask = 7'h01;
        tick();
        bus.clr = 1'b0;
        chk("t4_level0",  32'(bus.level[0]),       1);
        chk("t4_setwins", 32'(bus.edge_status[0]), EDGE_ON ? 32'h1 : 32'h0);
        bus.pin_in[0] = 1'b0;
        ticks(20);
        bus.clr      = 1'b1;
        bus.clr_mask = 7'h7F;
        tick();
        bus.clr = 1'b0;

        // 5: disable drops level without a fall flag; re-enable debounces
        bus.rise_mask = 7'h09;
        bus.fall_mask = 7'h09;
        bus.pin_in[3] = 1'b1;
        ticks(20);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        chk("t5_level3_hi", 32'(bus.level[3]), 1);
        bus.en[3] = 1'b0;
        tick();
        chk("t5_dis_level", 32'(bus.level[3]),    0);
        chk("t5_dis_stat",  32'(bus.edge_status), 0);
        ticks(3);
        bus.en[3] = 1'b1;
        wait_level(3, 1'b1, 30, lat);
        chk("t5_reen_lat",  lat, DEB);
        chk("t5_reen_rise", 32'(bus.edge_status[3]), EDGE_ON ? 32'h1 : 32'h0);

        // 6: reset mid-debounce
        bus.pin_in[1] = 1'b1;
        ticks(8);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_level",  32'(bus.level),       0);
        chk("t6_rst_status", 32'(bus.edge_status), 0);
        chk("t6_rst_irq",    32'(bus.irq),         0);
        ticks(2);
        @(negedge clk);
        rst_n = 1'b1;
        wait_level(1, 1'b1, 40, lat);
        chk("t6_post_lat", lat, SYNC + DEB);

        // Randomised phase against the model
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 29) == 0) bus.pin_in[i] = ~bus.pin_in[i];
            if ($urandom_range(0, 99) == 0) bus.en = W'($urandom);
            if ($urandom_range(0, 3) == 0)  bus.en = 7'h7F;
            if ($urandom_range(0, 49) == 0) begin
                bus.rise_mask = W'($urandom);
                bus.fall_mask = W'($urandom);
            end
            bus.clr      = ($urandom_range(0, 7) == 0);
            bus.clr_mask = W'($urandom);
            tick();
        end
        bus.clr = 1'b0;
        ticks(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
